// File: rtl/vbuf_pkg.sv
// Shared sizes and types for the vector buffer file.
package vbuf_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int TILE_WIDTH  = 256;
  localparam int TILE_ELEMS  = TILE_WIDTH / DATA_WIDTH;
  localparam int NUM_BUFS    = 32;
  localparam int DEPTH_TILES = 32;
  localparam int ID_W   = $clog2(NUM_BUFS);
  localparam int PTR_W  = $clog2(DEPTH_TILES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = ID_W + PTR_W;

  typedef logic [DATA_WIDTH-1:0] tile_t [TILE_ELEMS];
  typedef logic [ID_W-1:0]   id_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] tidx_t;
endpackage

// File: rtl/vector_buffer_file_tile_ram.sv
// 1W/1R tile storage; read register zeroes on request or reset.
module tile_ram
  import vbuf_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  tidx_t waddr,
  input  tile_t wdata,
  input  logic  re,
  input  logic  rz,
  input  tidx_t raddr,
  output tile_t rdata
);
  tile_t mem [NUM_BUFS*DEPTH_TILES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '{default: '0};
    end else if (re) begin
      rdata <= mem[raddr];
    end else if (rz) begin
      rdata <= '{default: '0};
    end
  end
endmodule

// File: rtl/vector_buffer_file.sv
// Multi-buffer tile FIFO file with armed level-request read port.
module vector_buffer_file
  import vbuf_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  write_en,
  input  id_t   write_id,
  input  tile_t write_data,
  output logic  write_done,
  output logic  wr_overflow,
  input  logic  buf_read_en,
  input  id_t   buf_read_id,
  output tile_t buf_read_data,
  output logic  buf_read_done,
  output logic  rd_underflow,
  input  logic  clear_en,
  input  logic  rewind_en,
  input  id_t   ctrl_id
);
  cnt_t wr_cnt_q [NUM_BUFS];
  ptr_t rd_ptr_q [NUM_BUFS];
  logic armed_q, armed_d;

  logic wr_blk, rd_blk;
  logic wr_go, wr_ok;
  logic rd_acc, rd_go, rd_hit;

  // Clear/rewind on the same id swallows the data op entirely
  assign wr_blk = (clear_en | rewind_en) & (ctrl_id == write_id);
  assign rd_blk = (clear_en | rewind_en) & (ctrl_id == buf_read_id);

  assign wr_go = write_en & ~wr_blk;
  assign wr_ok = wr_go &
    (wr_cnt_q[write_id] != cnt_t'(DEPTH_TILES));

  assign rd_acc = buf_read_en & armed_q;
  assign rd_go  = rd_acc & ~rd_blk;
  assign rd_hit = {1'b0, rd_ptr_q[buf_read_id]}
                < wr_cnt_q[buf_read_id];

  always_comb begin
    armed_d = armed_q;
    if (rd_acc)            armed_d = 1'b0;
    else if (!buf_read_en) armed_d = 1'b1;
  end

  tile_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({write_id, wr_cnt_q[write_id][PTR_W-1:0]}),
    .wdata (write_data),
    .re    (rd_go & rd_hit),
    .rz    (rd_go & ~rd_hit),
    .raddr ({buf_read_id, rd_ptr_q[buf_read_id]}),
    .rdata (buf_read_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        wr_cnt_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      armed_q       <= 1'b1;
      write_done    <= 1'b0;
      wr_overflow   <= 1'b0;
      buf_read_done <= 1'b0;
      rd_underflow  <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      write_done    <= wr_ok;
      wr_overflow   <= wr_go & ~wr_ok;
      buf_read_done <= rd_go;
      rd_underflow  <= rd_go & ~rd_hit;
      if (wr_ok)
        wr_cnt_q[write_id] <= wr_cnt_q[write_id] + 1'b1;
      if (rd_go & rd_hit)
        rd_ptr_q[buf_read_id] <= rd_ptr_q[buf_read_id] + 1'b1;
      if (clear_en) begin
        wr_cnt_q[ctrl_id] <= '0;
        rd_ptr_q[ctrl_id] <= '0;
      end else if (rewind_en) begin
        rd_ptr_q[ctrl_id] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vector_buffer_file.sv
// Random + directed bench for vector_buffer_file against a queue model.
module tb_vector_buffer_file;
  import vbuf_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  write_en;
  id_t   write_id;
  tile_t write_data;
  logic  write_done, wr_overflow;
  logic  buf_read_en;
  id_t   buf_read_id;
  tile_t buf_read_data;
  logic  buf_read_done, rd_underflow;
  logic  clear_en, rewind_en;
  id_t   ctrl_id;

  int checks = 0;
  int errors = 0;

  vector_buffer_file dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .write_id      (write_id),
    .write_data    (write_data),
    .write_done    (write_done),
    .wr_overflow   (wr_overflow),
    .buf_read_en   (buf_read_en),
    .buf_read_id   (buf_read_id),
    .buf_read_data (buf_read_data),
    .buf_read_done (buf_read_done),
    .rd_underflow  (rd_underflow),
    .clear_en      (clear_en),
    .rewind_en     (rewind_en),
    .ctrl_id       (ctrl_id)
  );

  always #5 clk = ~clk;

  // Reference: each buffer is the list of tiles written, plus a read index
  logic [255:0] mq [NUM_BUFS][$];
  int           mrd [NUM_BUFS];
  bit           marm;
  logic [255:0] mdata;

  task automatic chk(string tag, logic [255:0] got,
                     logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack(tile_t t);
    logic [255:0] p;
    for (int i = 0; i < TILE_ELEMS; i++) p[i*8 +: 8] = t[i];
    return p;
  endfunction

  function automatic logic [255:0] seqtile(int t);
    logic [255:0] p;
    for (int i = 0; i < TILE_ELEMS; i++) p[i*8 +: 8] = 8'(t*32 + i);
    return p;
  endfunction

  function automatic logic [255:0] rndtile();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NUM_BUFS; b++) begin
      mq[b].delete();
      mrd[b] = 0;
    end
    marm  = 1'b1;
    mdata = '0;
  endtask

  task automatic check_outs(string p, bit ewd, bit eov,
                            bit erd, bit euf);
    chk({p, "_wdone"}, 256'(write_done), 256'(ewd));
    chk({p, "_ovf"},   256'(wr_overflow), 256'(eov));
    chk({p, "_rdone"}, 256'(buf_read_done), 256'(erd));
    chk({p, "_udf"},   256'(rd_underflow), 256'(euf));
    chk({p, "_rdata"}, pack(buf_read_data), mdata);
  endtask

  task automatic drive(bit wen, int wid, logic [255:0] wd,
                       bit ren, int rid,
                       bit clr = 0, bit rew = 0, int cid = 0);
    bit wblk, rblk, acc;
    bit ewd, eov, erd, euf;
    write_en    = wen;
    write_id    = id_t'(wid);
    for (int i = 0; i < TILE_ELEMS; i++) write_data[i] = wd[i*8 +: 8];
    buf_read_en = ren;
    buf_read_id = id_t'(rid);
    clear_en    = clr;
    rewind_en   = rew;
    ctrl_id     = id_t'(cid);
    ewd = 0; eov = 0; erd = 0; euf = 0;
    wblk = (clr || rew) && cid == wid;
    rblk = (clr || rew) && cid == rid;
    acc  = ren && marm;
    if (acc)       marm = 1'b0;
    else if (!ren) marm = 1'b1;
    if (acc && !rblk) begin
      erd = 1;
      if (mrd[rid] < mq[rid].size()) begin
        mdata    = mq[rid][mrd[rid]];
        mrd[rid] = (mrd[rid] + 1) % DEPTH_TILES;
      end else begin
        mdata = '0;
        euf   = 1;
      end
    end
    if (wen && !wblk) begin
      if (mq[wid].size() < DEPTH_TILES) begin
        mq[wid].push_back(wd);
        ewd = 1;
      end else begin
        eov = 1;
      end
    end
    if (clr) begin
      mq[cid].delete();
      mrd[cid] = 0;
    end else if (rew) begin
      mrd[cid] = 0;
    end
    @(posedge clk);
    #1;
    check_outs("cyc", ewd, eov, erd, euf);
  endtask

  task automatic wr(int id, logic [255:0] d);
    drive(1, id, d, 0, 0);
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0);
  endtask

  task automatic rd(int id);
    drive(0, 0, '0, 1, id);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    write_en = 0; write_id = '0; buf_read_en = 0; buf_read_id = '0;
    clear_en = 0; rewind_en = 0; ctrl_id = '0;
    for (int i = 0; i < TILE_ELEMS; i++) write_data[i] = '0;
    model_reset();
    #12;
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    idle();

    for (int t = 0; t < 3; t++) wr(2, seqtile(t));
    for (int t = 0; t < 3; t++) rd(2);

    drive(0, 0, '0, 0, 0, 1, 0, 2);
    wr(2, seqtile(0));
    wr(2, seqtile(1));
    for (int k = 0; k < 3; k++) drive(0, 0, '0, 1, 2);
    idle();
    rd(2);

    rd(5);
    wr(5, seqtile(9));
    rd(5);

    for (int t = 0; t < 33; t++) wr(0, seqtile(t));
    rd(0);

    wr(7, seqtile(4));
    wr(7, seqtile(5));
    rd(7);
    drive(0, 0, '0, 0, 0, 0, 1, 7);
    rd(7);
    drive(0, 0, '0, 0, 0, 1, 0, 7);
    rd(7);

    drive(1, 1, seqtile(3), 0, 0, 1, 0, 1);
    rd(1);
    wr(4, seqtile(6));
    drive(1, 3, seqtile(8), 1, 4);
    idle();
    rd(3);

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      drive($urandom_range(0, 99) < 45, $urandom_range(0, 3), rndtile(),
            $urandom_range(0, 99) < 55, $urandom_range(0, 3),
            r < 4, r >= 4 && r < 8, $urandom_range(0, 3));
    end

    wr(6, seqtile(2));
    write_en = 1'b1;
    write_id = id_t'(6);
    buf_read_en = 1'b1;
    buf_read_id = id_t'(6);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_outs("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    idle();
    for (int b = 0; b < NUM_BUFS; b++) rd(b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_buffer_file.md
# vector_buffer_file

Shared on-chip vector buffer file that sits directly upstream of the store unit and downstream of load/compute units. It holds `NUM_BUFS` independent vector buffers, each a FIFO-ordered sequence of up to `DEPTH_TILES` tiles of `TILE_ELEMS` elements. A producer writes whole tiles. A consumer reads whole tiles in order through a level-request / done-pulse handshake that tolerates a request held high for several cycles.

## Interface
- `DATA_WIDTH`, 8: element width in bits
- `TILE_WIDTH`, 256: tile width in bits
- `TILE_ELEMS`, `TILE_WIDTH/DATA_WIDTH`: elements per tile
- `NUM_BUFS`, 32: number of buffers; id width is 5 bits
- `DEPTH_TILES`, 32: tiles per buffer, enough for 1024 elements
- `clk`, in, 1: clock
- `rst`, in, 1: reset, asynchronous, active-high
- `write_en`, in, 1: write one tile this cycle
- `write_id`, in, 5: target buffer
- `write_data`, in, `DATA_WIDTH` x `TILE_ELEMS` (unpacked array): tile to append
- `write_done`, out, 1: one-cycle pulse, tile accepted
- `wr_overflow`, out, 1: one-cycle pulse, write dropped because the buffer is full
- `buf_read_en`, in, 1: level read request
- `buf_read_id`, in, 5: buffer to read
- `buf_read_data`, out, `DATA_WIDTH` x `TILE_ELEMS`: tile returned by the last accepted read
- `buf_read_done`, out, 1: one-cycle pulse, `buf_read_data` is valid
- `rd_underflow`, out, 1: one-cycle pulse, the read had no written tile available
- `clear_en`, in, 1: empty buffer `ctrl_id`
- `rewind_en`, in, 1: reset the read pointer of buffer `ctrl_id`
- `ctrl_id`, in, 5: target of clear/rewind

## Operation
- Per-buffer state: `wr_cnt` (0..`DEPTH_TILES`, 6 bits) and `rd_ptr` (0..`DEPTH_TILES`-1, 5 bits). Storage address is {id, pointer}.
- **Write**
  - When `write_en=1` and `wr_cnt[write_id] < DEPTH_TILES`: store the tile at `wr_cnt`, increment `wr_cnt`, and pulse `write_done` on the next cycle.
  - When the buffer is full: store nothing, pulse `wr_overflow` instead.
  - `write_en` is level-sensitive, so every high cycle is a separate write.
- **Read arming**
  - The read port holds an `armed` flag, set at reset.
  - A read is accepted on an edge where `buf_read_en=1` and `armed=1`. Acceptance clears `armed`.
  - `armed` sets again on the first edge that samples `buf_read_en=0`.
  - While disarmed, `buf_read_en=1` is ignored. A consumer may therefore keep the request registered high for 1–3 extra cycles after done without causing a double read.
- **Accepted read**
  - If `rd_ptr < wr_cnt`: `buf_read_data` is set to the tile at `rd_ptr`, and `rd_ptr` increments, wrapping from `DEPTH_TILES`-1 to 0.
  - Otherwise: `buf_read_data` is set to all zeros, `rd_underflow` pulses, and `rd_ptr` is unchanged.
  - In both cases `buf_read_done` pulses.
- **Hold**: `buf_read_data` holds until the next accepted read. Consumers index it for many cycles after done.
- **Clear**: `clear_en` sets `wr_cnt` and `rd_ptr` of `ctrl_id` to 0.
- **Rewind**: `rewind_en` sets `rd_ptr` of `ctrl_id` to 0, allowing a vector to be re-read.
- **Simultaneous events**
  - `clear_en` beats `rewind_en`.
  - A clear or rewind on a buffer beats a same-cycle read or write on that buffer. The dropped write or read still produces no done and no error pulse. The arm flag is still consumed.
  - A read and a write to the same buffer in one cycle: the read sees pre-write `wr_cnt` (read-before-write).
  - Operations on different ids are fully independent.

## Timing
- Read latency: request sampled at edge k → `buf_read_done` and data valid in the cycle after edge k.
- Write latency: data sampled at edge k → readable by a read accepted at edge k+1 or later; `write_done` in the cycle after edge k.
- All outputs are registered.
- Reset values:
  - `buf_read_data` all zeros.
  - `buf_read_done`, `write_done`, `wr_overflow`, `rd_underflow` = 0.
  - All `wr_cnt` and `rd_ptr` = 0; `armed` = 1.
  - Tile storage contents are not reset. They are gated by `wr_cnt`.
- Reset asserted mid-operation aborts everything. Pending pulses are not emitted. All buffers read as empty afterward.

## Structure
- Package `vbuf_pkg`: `DATA_WIDTH`, `TILE_ELEMS`, `NUM_BUFS`, `DEPTH_TILES`, id width, the tile typedef (unpacked element array), and the tile-index typedef.
- Sub-module `tile_ram`: synchronous 1-write/1-read RAM of `NUM_BUFS*DEPTH_TILES` tiles with registered read data, no reset on the array. The pointer, arming and flag logic lives in the top.

## Test plan
- Write 3 tiles (element i = tile*32+i) to buf 2, then issue 3 single-cycle reads → three `buf_read_done` pulses returning tiles 0, 1, 2 in order; `rd_underflow` never asserts.
- Hold `buf_read_en` high for 3 cycles on buf 2 with 2 tiles written → exactly one done, tile 0 returned; drop the request, reassert → tile 1 returned.
- Read an empty buf 5 → done and `rd_underflow` pulse together, data all zeros, `rd_ptr` stays 0; then write 1 tile, read → tile returned.
- Write 33 tiles to buf 0 → 32 `write_done` pulses and 1 `wr_overflow` pulse on the 33rd write.
- Write 2 tiles to buf 7, read 1, `rewind_en` → the next read returns tile 0; `clear_en` → the next read underflows.
- Same-cycle `clear_en` on buf 1 and write to buf 1 → no `write_done`, buf 1 is empty. Write to buf 3 in parallel with a read of buf 4 → both succeed. Assert `rst` mid-sequence → all outputs 0 and every buffer reads as underflow.
